serial_shift_unit: RTL and testbench



---
 rtl/serial_shift_unit.sv | 130 +++++++++++++
 tb/tb_serial_shift_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_unit.sv
// rtl/serial_shift_unit.sv - multi-cycle shifter, STEP bits per clock; rotate-right enabled by SERIAL_SHIFT_ROTATE_EN
module serial_shift_unit #(
   parameter int WORD_LENGTH = 32,
   parameter int SHAMT_BITS  = 5,
   parameter int STEP        = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   Start,
   input  logic [1:0]             ShiftOp,
   input  logic [WORD_LENGTH-1:0] DataInput,
   input  logic [WORD_LENGTH-1:0] ShamtInput,
   output logic                   Busy,
   output logic                   Done,
   output logic [WORD_LENGTH-1:0] ShiftResult
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } stateType;

   localparam logic [SHAMT_BITS-1:0] STEP_COUNT = SHAMT_BITS'(STEP);

   stateType               state;
   stateType               nextState;
   logic [WORD_LENGTH-1:0] workReg;
   logic [WORD_LENGTH-1:0] nextWork;
   logic [WORD_LENGTH-1:0] shiftedWork;
   logic [SHAMT_BITS-1:0]  countReg;
   logic [SHAMT_BITS-1:0]  nextCount;
   logic [SHAMT_BITS-1:0]  acceptCount;
   logic [SHAMT_BITS-1:0]  stepAmt;
   logic [1:0]             opReg;
   logic [1:0]             nextOp;

   // The extended shamt word only carries a count in its low field.
   logic unusedShamtBits;
   assign unusedShamtBits = ^ShamtInput[WORD_LENGTH-1:SHAMT_BITS];

   // Count loaded at acceptance; an unsupported op collapses to a pass-through.
   always_comb begin
      acceptCount = ShamtInput[SHAMT_BITS-1:0];
`ifndef SERIAL_SHIFT_ROTATE_EN
      if (ShiftOp == 2'b11) begin
         acceptCount = '0;
      end
`endif
   end

   // Clip this cycle's step to the remaining count so the count never underflows.
   always_comb begin
      stepAmt = (countReg < STEP_COUNT) ? countReg : STEP_COUNT;
   end

   // One step of the latched operation applied to the work register.
   always_comb begin
      shiftedWork = workReg;
      case (opReg)
         2'b00:   shiftedWork = workReg << stepAmt;
         2'b01:   shiftedWork = workReg >> stepAmt;
         2'b10:   shiftedWork = WORD_LENGTH'($signed(workReg) >>> stepAmt);
`ifdef SERIAL_SHIFT_ROTATE_EN
         2'b11:   shiftedWork = (workReg >> stepAmt)
                              | (workReg << (WORD_LENGTH - int'(stepAmt)));
`endif
         default: shiftedWork = workReg;
      endcase
   end

   // Next-state, next-datapath and handshake outputs.
   always_comb begin
      nextState = state;
      nextWork  = workReg;
      nextCount = countReg;
      nextOp    = opReg;
      Busy      = (state != IDLE);
      Done      = 1'b0;
      case (state)
         IDLE: begin
            if (Start) begin
               nextWork  = DataInput;
               nextCount = acceptCount;
               nextOp    = ShiftOp;
               nextState = (acceptCount == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            nextWork  = shiftedWork;
            nextCount = countReg - stepAmt;
            if (countReg == stepAmt) begin
               nextState = DONE;
            end
         end
         DONE: begin
            Done      = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // State register; reset aborts any in-flight operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Datapath registers; the result is captured only on entry to DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         workReg     <= '0;
         countReg    <= '0;
         opReg       <= 2'b00;
         ShiftResult <= '0;
      end else begin
         workReg  <= nextWork;
         countReg <= nextCount;
         opReg    <= nextOp;
         if (nextState == DONE && state != DONE) begin
            ShiftResult <= nextWork;
         end
      end
   end

endmodule

// File: tb/tb_serial_shift_unit.sv
// tb/tb_serial_shift_unit.sv - scoreboard bench for serial_shift_unit
module tb_serial_shift_unit;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [1:0]  ShiftOp;
   logic [31:0] DataInput;
   logic [31:0] ShamtInput;
   logic        Busy;
   logic        Done;
   logic [31:0] ShiftResult;

   typedef struct {
      logic [31:0] result;
      int          doneCycle;
      int          latency;
      string       name;
   } expType;

   expType expQueue[$];
   int     checks;
   int     failures;
   int     cycleCnt;
   int     busyRun;

   serial_shift_unit #(.WORD_LENGTH(32), .SHAMT_BITS(5), .STEP(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .Start      (Start),
      .ShiftOp    (ShiftOp),
      .DataInput  (DataInput),
      .ShamtInput (ShamtInput),
      .Busy       (Busy),
      .Done       (Done),
      .ShiftResult(ShiftResult)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever Done is presented.
   always @(negedge clk) begin
      expType e;
      if (Busy === 1'b1) busyRun++;
      else busyRun = 0;
      if (Done === 1'b1) begin
         if (expQueue.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got Done=1 with result 0x%08h at cycle %0d, expected no Done", ShiftResult, cycleCnt);
         end else begin
            e = expQueue.pop_front();
            check({e.name, "_result"}, ShiftResult, e.result);
            check({e.name, "_latency"}, cycleCnt, e.doneCycle);
            check({e.name, "_busy_cycles"}, busyRun, e.latency);
         end
      end
   end

   task automatic issue(input string name, input logic [1:0] op, input logic [31:0] data,
                        input logic [31:0] shamt, input logic [31:0] expRes, input int lat,
                        input bit push);
      expType e;
      @(negedge clk);
      ShiftOp    = op;
      DataInput  = data;
      ShamtInput = shamt;
      Start      = 1'b1;
      if (push) begin
         e.result    = expRes;
         e.doneCycle = cycleCnt + lat;
         e.latency   = lat;
         e.name      = name;
         expQueue.push_back(e);
      end
      @(posedge clk);
      #1;
      Start      = 1'b0;
      DataInput  = 32'hA5A5A5A5;
      ShamtInput = 32'h0000001F;
      ShiftOp    = 2'b01;
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (expQueue.size() != 0 && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (expQueue.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL timeout: %0d results still pending, expected 0", expQueue.size());
         expQueue.delete();
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cycleCnt = 0;
      busyRun  = 0;
      reset      = 1'b0;
      Start      = 1'b0;
      ShiftOp    = 2'b00;
      DataInput  = 32'h0;
      ShamtInput = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_busy", {31'd0, Busy}, 32'd0);
      check("reset_done", {31'd0, Done}, 32'd0);
      check("reset_result", ShiftResult, 32'h00000000);

      issue("sll31", 2'b00, 32'h00000001, 32'h0000001F, 32'h80000000, 32, 1'b1);
      waitDrain(60);
      issue("srl4", 2'b01, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 5, 1'b1);
      waitDrain(20);
      issue("sra4", 2'b10, 32'h80000000, 32'hFFFFFFE4, 32'hF8000000, 5, 1'b1);
      waitDrain(20);
      issue("sra_pos", 2'b10, 32'h70000000, 32'h00000004, 32'h07000000, 5, 1'b1);
      waitDrain(20);
      issue("sll16", 2'b00, 32'hFFFFFFFF, 32'h00000010, 32'hFFFF0000, 17, 1'b1);
      waitDrain(40);
      issue("srl31", 2'b01, 32'hFFFFFFFF, 32'h0000001F, 32'h00000001, 32, 1'b1);
      waitDrain(60);
      issue("zero_shamt", 2'b00, 32'h12345678, 32'h00000000, 32'h12345678, 1, 1'b1);
      waitDrain(10);

      issue("sll8_busy", 2'b00, 32'h12345678, 32'h00000008, 32'h34567800, 9, 1'b1);
      repeat (2) @(negedge clk);
      issue("ignored", 2'b01, 32'hDEADBEEF, 32'h00000000, 32'h0, 1, 1'b0);
      waitDrain(30);

      // back-to-back: the next Start lands in the IDLE cycle right after Done
      issue("b2b_a", 2'b01, 32'h000000F0, 32'h00000004, 32'h0000000F, 5, 1'b1);
      waitDrain(20);
      issue("b2b_b", 2'b00, 32'h0000000F, 32'h00000004, 32'h000000F0, 5, 1'b1);
      waitDrain(20);

      issue("abort", 2'b00, 32'h00000001, 32'h00000014, 32'h0, 21, 1'b0);
      repeat (6) @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("abort_busy", {31'd0, Busy}, 32'd0);
      check("abort_done", {31'd0, Done}, 32'd0);
      check("abort_result", ShiftResult, 32'h00000000);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);
      issue("post_reset", 2'b00, 32'h00000003, 32'h00000001, 32'h00000006, 2, 1'b1);
      waitDrain(10);

`ifdef SERIAL_SHIFT_ROTATE_EN
      issue("ror1", 2'b11, 32'h00000001, 32'h00000001, 32'h80000000, 2, 1'b1);
      waitDrain(10);
      issue("ror4", 2'b11, 32'h0000000F, 32'h00000004, 32'hF0000000, 5, 1'b1);
      waitDrain(20);
`else
      issue("op11_pass", 2'b11, 32'h00000001, 32'h00000001, 32'h00000001, 1, 1'b1);
      waitDrain(10);
      issue("op11_pass4", 2'b11, 32'h0000000F, 32'h00000004, 32'h0000000F, 1, 1'b1);
      waitDrain(10);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
